// File: rtl/addr_seq_pkg.sv
// Shared types and default widths for the address sequencer and its step unit.
package addr_seq_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_STEP_WIDTH = 4;
  localparam int DEF_LEN_WIDTH  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/addr_step_unit.sv
// Combinational stride step with optional circular-window wrap.
// Shared by IDLE increment/decrement and BURST beat advance.
module addr_step_unit
  import addr_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int STEP_WIDTH = DEF_STEP_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [STEP_WIDTH-1:0] step,
  input  dir_t                  dir,
  input  logic                  wrap_en,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] limit,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  wrapped
);

  localparam int XW = ADDR_WIDTH + 1;
  localparam logic [XW-1:0] ONE_X = XW'(1);

  logic [XW-1:0] addr_x_s;
  logic [XW-1:0] step_x_s;
  logic [XW-1:0] base_x_s;
  logic [XW-1:0] limit_x_s;
  logic [XW-1:0] sum_s;
  logic [XW-1:0] diff_s;
  logic [XW-1:0] base_step_s;
  logic          in_window_s;

  assign addr_x_s    = {1'b0, addr};
  assign step_x_s    = XW'(step);
  assign base_x_s    = {1'b0, base};
  assign limit_x_s   = {1'b0, limit};
  assign sum_s       = addr_x_s + step_x_s;
  assign diff_s      = addr_x_s - step_x_s;
  assign base_step_s = base_x_s + step_x_s;
  assign in_window_s = wrap_en && (addr >= base) && (addr <= limit);

  // Next address: window fold when inside the window, plain modulo with carry/borrow otherwise.
  always_comb begin
    next_addr = addr;
    wrapped   = 1'b0;
    case (dir)
      DIR_UP: begin
        if (in_window_s) begin
          if (sum_s > limit_x_s) begin
            next_addr = ADDR_WIDTH'(base_x_s + (sum_s - limit_x_s - ONE_X));
            wrapped   = 1'b1;
          end else begin
            next_addr = sum_s[ADDR_WIDTH-1:0];
            wrapped   = 1'b0;
          end
        end else begin
          next_addr = sum_s[ADDR_WIDTH-1:0];
          wrapped   = sum_s[ADDR_WIDTH];
        end
      end
      DIR_DOWN: begin
        if (in_window_s) begin
          if (addr_x_s < base_step_s) begin
            next_addr = ADDR_WIDTH'(limit_x_s - (base_step_s - addr_x_s - ONE_X));
            wrapped   = 1'b1;
          end else begin
            next_addr = diff_s[ADDR_WIDTH-1:0];
            wrapped   = 1'b0;
          end
        end else begin
          next_addr = diff_s[ADDR_WIDTH-1:0];
          wrapped   = diff_s[ADDR_WIDTH];
        end
      end
      default: begin
        next_addr = addr;
        wrapped   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/address_sequencer.sv
// Memory address register with load, stride step, windowed wrap and
// handshaked autonomous bursts for RAM block transfers and ring buffers.
module address_sequencer
  import addr_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int STEP_WIDTH = DEF_STEP_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_value,
  input  logic                  increment,
  input  logic                  decrement,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic                  wrap_en,
  input  logic [ADDR_WIDTH-1:0] wrap_base,
  input  logic [ADDR_WIDTH-1:0] wrap_limit,
  input  logic                  burst_start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  addr_ready,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  addr_valid,
  output logic                  busy,
  output logic                  burst_done,
  output logic                  wrapped
);

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [LEN_WIDTH-1:0]    remaining_r;
  logic                    busy_r;
  logic                    burst_done_r;
  logic                    wrapped_r;
  dir_t                    dir_s;
  logic [ADDR_WIDTH-1:0]   next_addr_s;
  logic                    step_wrapped_s;

  // Bursts always walk upward; IDLE walks down only on a lone decrement.
  always_comb begin
    if ((state_r == IDLE) && decrement && !increment) begin
      dir_s = DIR_DOWN;
    end else begin
      dir_s = DIR_UP;
    end
  end

  addr_step_unit #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STEP_WIDTH (STEP_WIDTH)
  ) u_step (
    .addr      (addr_r),
    .step      (step),
    .dir       (dir_s),
    .wrap_en   (wrap_en),
    .base      (wrap_base),
    .limit     (wrap_limit),
    .next_addr (next_addr_s),
    .wrapped   (step_wrapped_s)
  );

  // Sequencer FSM: IDLE commands by priority, BURST beats on handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      addr_r       <= {ADDR_WIDTH{1'b0}};
      remaining_r  <= {LEN_WIDTH{1'b0}};
      busy_r       <= 1'b0;
      burst_done_r <= 1'b0;
      wrapped_r    <= 1'b0;
    end else begin
      burst_done_r <= 1'b0;
      wrapped_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (burst_start && (burst_len != {LEN_WIDTH{1'b0}})) begin
            state_r     <= BURST;
            busy_r      <= 1'b1;
            remaining_r <= burst_len;
          end else if (load) begin
            addr_r <= load_value;
          end else if (increment ^ decrement) begin
            addr_r    <= next_addr_s;
            wrapped_r <= step_wrapped_s;
          end else begin
            addr_r <= addr_r;
          end
        end
        BURST: begin
          if (addr_ready) begin
            addr_r      <= next_addr_s;
            wrapped_r   <= step_wrapped_s;
            remaining_r <= remaining_r - LEN_WIDTH'(1);
            if (remaining_r == LEN_WIDTH'(1)) begin
              state_r      <= IDLE;
              busy_r       <= 1'b0;
              burst_done_r <= 1'b1;
            end else begin
              state_r <= BURST;
            end
          end else begin
            addr_r <= addr_r;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign addr_out   = addr_r;
  assign addr_valid = busy_r;
  assign busy       = busy_r;
  assign burst_done = burst_done_r;
  assign wrapped    = wrapped_r;

endmodule

// File: tb/tb_address_sequencer.sv
// Scoreboard bench: integer reference model predicts each cycle's outputs,
// a monitor compares them one cycle later.
module tb_address_sequencer;

  logic       clk = 1'b0;
  logic       reset, load, increment, decrement, wrap_en, burst_start, addr_ready;
  logic [7:0] load_value, wrap_base, wrap_limit;
  logic [3:0] step, burst_len;
  logic [7:0] addr_out;
  logic       addr_valid, busy, burst_done, wrapped;

  typedef struct packed {
    logic [7:0] addr;
    logic       valid;
    logic       busy;
    logic       done;
    logic       wr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int m_addr = 0;
  int m_rem  = 0;
  bit m_busy = 1'b0;

  always #5 clk = ~clk;

  address_sequencer dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .increment(increment), .decrement(decrement), .step(step),
    .wrap_en(wrap_en), .wrap_base(wrap_base), .wrap_limit(wrap_limit),
    .burst_start(burst_start), .burst_len(burst_len), .addr_ready(addr_ready),
    .addr_out(addr_out), .addr_valid(addr_valid), .busy(busy),
    .burst_done(burst_done), .wrapped(wrapped)
  );

  function automatic int step_up(input int a, output bit w);
    int s = a + int'(step);
    if (wrap_en && a >= int'(wrap_base) && a <= int'(wrap_limit)) begin
      w = (s > int'(wrap_limit));
      return w ? ((int'(wrap_base) + s - int'(wrap_limit) - 1) & 255) : s;
    end
    w = (s > 255);
    return s & 255;
  endfunction

  function automatic int step_down(input int a, output bit w);
    int d = a - int'(step);
    if (wrap_en && a >= int'(wrap_base) && a <= int'(wrap_limit)) begin
      w = (a < int'(wrap_base) + int'(step));
      return w ? ((int'(wrap_limit) - (int'(wrap_base) + int'(step) - a - 1)) & 255) : d;
    end
    w = (d < 0);
    return d & 255;
  endfunction

  // Apply the currently driven inputs to the model, queue what the DUT should show, wait a cycle.
  task automatic tick();
    exp_t e;
    bit   w = 1'b0;
    bit   done = 1'b0;
    if (reset) begin
      m_addr = 0; m_busy = 1'b0; m_rem = 0;
    end else if (!m_busy) begin
      if (burst_start && burst_len != 4'd0) begin
        m_busy = 1'b1; m_rem = int'(burst_len);
      end else if (load) m_addr = int'(load_value);
      else if (increment && !decrement) m_addr = step_up(m_addr, w);
      else if (decrement && !increment) m_addr = step_down(m_addr, w);
    end else if (addr_ready) begin
      m_addr = step_up(m_addr, w);
      m_rem  = m_rem - 1;
      if (m_rem == 0) begin
        m_busy = 1'b0; done = 1'b1;
      end
    end
    e.addr = 8'(m_addr); e.valid = m_busy; e.busy = m_busy; e.done = done; e.wr = w;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic quiet();
    reset = 1'b0; load = 1'b0; increment = 1'b0; decrement = 1'b0;
    burst_start = 1'b0; addr_ready = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pop the expectation queued for this edge and compare every output.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("addr_out",   int'(addr_out),   int'(e.addr));
      check("addr_valid", int'(addr_valid), int'(e.valid));
      check("busy",       int'(busy),       int'(e.busy));
      check("burst_done", int'(burst_done), int'(e.done));
      check("wrapped",    int'(wrapped),    int'(e.wr));
    end
  end

  initial begin
    quiet();
    load_value = 8'h00; step = 4'd0; wrap_en = 1'b0;
    wrap_base = 8'h00; wrap_limit = 8'hFF; burst_len = 4'd0;

    reset = 1'b1; tick(); tick(); quiet(); tick();

    // Carry-out wrap without a window
    load = 1'b1; load_value = 8'hFE; tick(); quiet();
    step = 4'd1; increment = 1'b1; tick(); tick(); quiet(); tick();

    // Window fold up and down
    wrap_en = 1'b1; wrap_base = 8'h10; wrap_limit = 8'h17;
    load = 1'b1; load_value = 8'h16; tick(); quiet();
    step = 4'd3; increment = 1'b1; tick(); quiet();
    decrement = 1'b1; tick(); quiet(); tick();

    // Burst with ready held high
    wrap_en = 1'b0;
    load = 1'b1; load_value = 8'h20; tick(); quiet();
    step = 4'd2; burst_len = 4'd3; burst_start = 1'b1; addr_ready = 1'b1; tick();
    burst_start = 1'b0; tick(); tick(); tick(); tick(); quiet(); tick();

    // Backpressure with commands that must be ignored
    burst_len = 4'd2; burst_start = 1'b1; tick(); quiet();
    for (int i = 0; i < 3; i++) begin
      load = 1'b1; load_value = 8'h99; increment = 1'b1; burst_start = 1'b1; tick();
    end
    quiet(); addr_ready = 1'b1; tick(); tick(); tick(); quiet(); tick();

    // Simultaneous increment/decrement, then zero-length burst with load
    increment = 1'b1; decrement = 1'b1; tick(); quiet();
    burst_start = 1'b1; burst_len = 4'd0; load = 1'b1; load_value = 8'h40; tick(); quiet(); tick();

    // Reset mid-burst
    burst_start = 1'b1; burst_len = 4'd5; addr_ready = 1'b1; tick(); quiet();
    addr_ready = 1'b1; tick(); reset = 1'b1; tick(); tick(); quiet(); tick(); tick();

    // Randomised traffic with legal windows
    for (int i = 0; i < 3000; i++) begin
      quiet();
      if ($urandom_range(0, 63) == 0) begin
        wrap_en = 1'($urandom_range(0, 1));
        wrap_base = 8'($urandom_range(0, 200));
        wrap_limit = 8'(int'(wrap_base) + $urandom_range(0, 55));
      end
      if (wrap_en && int'(wrap_limit) - int'(wrap_base) + 1 < 15)
        step = 4'($urandom_range(0, int'(wrap_limit) - int'(wrap_base) + 1));
      else
        step = 4'($urandom_range(0, 15));
      reset       = ($urandom_range(0, 199) == 0);
      load        = ($urandom_range(0, 7) == 0);
      load_value  = 8'($urandom);
      increment   = ($urandom_range(0, 2) == 0);
      decrement   = ($urandom_range(0, 2) == 0);
      burst_start = ($urandom_range(0, 9) == 0);
      burst_len   = 4'($urandom_range(0, 15));
      addr_ready  = ($urandom_range(0, 9) < 7);
      tick();
    end

    quiet(); tick(); @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
